// File: rtl/pll_presc_pkg.sv
// Shared types and default parameters for the PLL lock prescaler.
package pll_presc_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int DEF_CNT_W      = 24;
  localparam int DEF_TAP0       = 21;
  localparam int DEF_TAP1       = 22;
  localparam int DEF_TAP2       = 23;
  localparam int DEF_SETTLE_CYC = 1024;

endpackage

// File: rtl/pll_lock_prescaler_sync2.sv
// Two-flop synchronizer, async active-low reset to 0.
module sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_prescaler.sv
// PLL lock qualifier and prescaler: waits for a stable lock, then runs a divider chain.
// Optional tick strobes are built only when PRESCALER_TICK_EN is defined.
//
// state     | meaning
// WAIT_LOCK | waiting for synchronized lock
// SETTLE    | lock seen, counting SETTLE_CYC stable cycles
// RUN       | lock qualified, prescaler counting, ready_o high
module pll_lock_prescaler
  import pll_presc_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int TAP0       = DEF_TAP0,
  parameter int TAP1       = DEF_TAP1,
  parameter int TAP2       = DEF_TAP2,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       lock_i,
  output logic       ready_o,
  output logic [2:0] div_o,
  output logic [2:0] tick_o,
  output logic [1:0] state_o
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  logic             lock_s;
  state_t           state;
  logic [SET_W-1:0] settle_cnt;
  logic [CNT_W-1:0] presc_cnt;

  sync2 u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (lock_i),
    .q    (lock_s)
  );

  // Loss of lock outranks every other transition; counter and ready clear by default.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      presc_cnt  <= '0;
      ready_o    <= 1'b0;
    end else begin
      ready_o   <= 1'b0;
      presc_cnt <= '0;
      case (state)
        WAIT_LOCK: begin
          settle_cnt <= '0;
          if (lock_s) state <= SETTLE;
        end
        SETTLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else if (settle_cnt == SETTLE_LAST) begin
            state   <= RUN;
            ready_o <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else begin
            ready_o   <= 1'b1;
            presc_cnt <= presc_cnt + CNT_W'(1);
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

  assign state_o = state;
  assign div_o   = {presc_cnt[TAP2], presc_cnt[TAP1], presc_cnt[TAP0]};

`ifdef PRESCALER_TICK_EN
  // Gating on lock_s drops a tick that would otherwise land on the exit edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_o <= '0;
    end else if (state == RUN && lock_s) begin
      tick_o <= {&presc_cnt[TAP2:0], &presc_cnt[TAP1:0], &presc_cnt[TAP0:0]};
    end else begin
      tick_o <= '0;
    end
  end
`else
  assign tick_o = '0;
`endif

endmodule

// File: tb/tb_pll_lock_prescaler.sv
// Directed bench for pll_lock_prescaler (CNT_W=6, taps 1/2/3, SETTLE_CYC=4).
module tb_pll_lock_prescaler;

  logic       clk = 1'b0;
  logic       rstn;
  logic       lock_i;
  logic       ready_o;
  logic [2:0] div_o;
  logic [2:0] tick_o;
  logic [1:0] state_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pll_lock_prescaler #(
    .CNT_W      (6),
    .TAP0       (1),
    .TAP1       (2),
    .TAP2       (3),
    .SETTLE_CYC (4)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .lock_i  (lock_i),
    .ready_o (ready_o),
    .div_o   (div_o),
    .tick_o  (tick_o),
    .state_o (state_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // j = cycles spent in RUN; counter equals j at the edge after entry + j.
  function automatic logic [2:0] exp_div(input int j);
    logic [5:0] c;
    c = 6'(j);
    return {c[3], c[2], c[1]};
  endfunction

  function automatic logic [2:0] exp_tick(input int j);
    logic [2:0] t;
    t = 3'b000;
`ifdef PRESCALER_TICK_EN
    if (j > 0) begin
      t[0] = (j % 4)  == 0;
      t[1] = (j % 8)  == 0;
      t[2] = (j % 16) == 0;
    end
`endif
    return t;
  endfunction

  // State after each edge following reset release; edge 1 is the first sample of lock_i.
  logic [1:0] st_rel [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
  // State after each edge in the lock-glitch scenario (edges 5..12).
  logic [1:0] st_gl  [8] = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};

  initial begin
    rstn   = 1'b0;
    lock_i = 1'b1;
    step();
    step();
    check("rst_ready", {7'd0, ready_o}, 8'd0);
    check("rst_div",   {5'd0, div_o},   8'd0);
    check("rst_tick",  {5'd0, tick_o},  8'd0);
    check("rst_state", {6'd0, state_o}, 8'd0);

    rstn = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      check($sformatf("rel_state_e%0d", k + 1), {6'd0, state_o}, {6'd0, st_rel[k]});
      check($sformatf("rel_ready_e%0d", k + 1), {7'd0, ready_o}, {7'd0, k == 6});
    end

    // Entry edge (j=0) already checked above for state; now the RUN window.
    check("run_div_j0",  {5'd0, div_o},  {5'd0, exp_div(0)});
    check("run_tick_j0", {5'd0, tick_o}, {5'd0, exp_tick(0)});
    for (int j = 1; j <= 34; j++) begin
      step();
      check($sformatf("run_div_j%0d", j),  {5'd0, div_o},  {5'd0, exp_div(j)});
      check($sformatf("run_tick_j%0d", j), {5'd0, tick_o}, {5'd0, exp_tick(j)});
      check($sformatf("run_ready_j%0d", j), {7'd0, ready_o}, 8'd1);
    end

    // Asynchronous reset between edges while div_o is nonzero.
    #3 rstn = 1'b0;
    #1;
    check("arst_ready", {7'd0, ready_o}, 8'd0);
    check("arst_div",   {5'd0, div_o},   8'd0);
    check("arst_tick",  {5'd0, tick_o},  8'd0);
    check("arst_state", {6'd0, state_o}, 8'd0);
    #2 rstn = 1'b1;

    // Full re-lock needed: ready only at the 7th edge after release.
    for (int k = 0; k < 7; k++) begin
      step();
      check($sformatf("relock_ready_e%0d", k + 1), {7'd0, ready_o}, {7'd0, k == 6});
    end
    for (int j = 1; j <= 5; j++) step();
    check("pre_drop_div_j5", {5'd0, div_o}, {5'd0, exp_div(5)});

    // Drop lock so the FSM leaves RUN during the cycle with counter=7 (ticks pending there).
    lock_i = 1'b0;
    step();
    check("drop_div_j6",   {5'd0, div_o},   {5'd0, exp_div(6)});
    check("drop_ready_j6", {7'd0, ready_o}, 8'd1);
    step();
    check("drop_div_j7",   {5'd0, div_o},   {5'd0, exp_div(7)});
    check("drop_tick_j7",  {5'd0, tick_o},  {5'd0, exp_tick(7)});
    step();
    check("exit_ready", {7'd0, ready_o}, 8'd0);
    check("exit_div",   {5'd0, div_o},   8'd0);
    check("exit_tick",  {5'd0, tick_o},  8'd0);
    check("exit_state", {6'd0, state_o}, 8'd0);
    step();
    check("exit_tick_after", {5'd0, tick_o}, 8'd0);
    check("exit_div_after",  {5'd0, div_o},  8'd0);

    // One-cycle lock glitch during SETTLE.
    lock_i = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("gl_settle_e4", {6'd0, state_o}, 8'd1);
    lock_i = 1'b0;
    step();
    lock_i = 1'b1;
    check($sformatf("gl_state_e%0d", 5), {6'd0, state_o}, {6'd0, st_gl[0]});
    for (int k = 1; k < 8; k++) begin
      step();
      check($sformatf("gl_state_e%0d", k + 5), {6'd0, state_o}, {6'd0, st_gl[k]});
      check($sformatf("gl_ready_e%0d", k + 5), {7'd0, ready_o}, {7'd0, k == 7});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
